ex_div: RTL

- Iterative radix-2 restoring divider for DIV/DIVU, instantiated inside the EX stage.
- Consumes the EX-stage operands (ex_reg1 = dividend, ex_reg2 = divisor) registered by the ID/EX pipeline register.
- The EX stage holds the pipeline stalled until ready asserts, then writes {remainder, quotient} into HI/LO.
- Exception flush annuls an in-flight division.

---
 rtl/ex_div.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after DATA_W iterations; sign fix applied on the last one.
module ex_div #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  signed_div,
   input  logic [DATA_W-1:0]     dividend,
   input  logic [DATA_W-1:0]     divisor,
   input  logic                  annul,
   output logic [2*DATA_W-1:0]   result,
   output logic                  ready,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;

   localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

   state_t                state_reg, state_next;
   logic [5:0]            cnt_reg, cnt_next;
   logic [DATA_W-1:0]     rem_reg, rem_next;
   logic [DATA_W-1:0]     quo_reg, quo_next;
   logic [DATA_W-1:0]     dvs_reg, dvs_next;
   logic                  sgn_reg, sgn_next;
   logic                  neg_q_reg, neg_q_next;
   logic                  neg_r_reg, neg_r_next;
   logic [2*DATA_W-1:0]   result_reg, result_next;
   logic                  ready_reg, ready_next;

   logic [DATA_W:0]       partial;
   logic [DATA_W:0]       diff;
   logic [DATA_W-1:0]     rem_step, quo_step, rem_fix, quo_fix;
   logic [DATA_W-1:0]     abs_dvd, abs_dvs;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         dvs_reg    <= '0;
         sgn_reg    <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         result_reg <= '0;
         ready_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         rem_reg    <= rem_next;
         quo_reg    <= quo_next;
         dvs_reg    <= dvs_next;
         sgn_reg    <= sgn_next;
         neg_q_reg  <= neg_q_next;
         neg_r_reg  <= neg_r_next;
         result_reg <= result_next;
         ready_reg  <= ready_next;
      end
   end

   // One restoring step: the partial remainder always fits DATA_W+1 bits,
   // so the MSB of the difference is the borrow.
   always_comb begin
      partial  = {rem_reg, quo_reg[DATA_W-1]};
      diff     = partial - {1'b0, dvs_reg};
      rem_step = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
      quo_step = {quo_reg[DATA_W-2:0], ~diff[DATA_W]};
      quo_fix  = (sgn_reg && neg_q_reg) ? -quo_step : quo_step;
      rem_fix  = (sgn_reg && neg_r_reg) ? -rem_step : rem_step;
      abs_dvd  = (signed_div && dividend[DATA_W-1]) ? -dividend : dividend;
      abs_dvs  = (signed_div && divisor[DATA_W-1])  ? -divisor  : divisor;
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      rem_next    = rem_reg;
      quo_next    = quo_reg;
      dvs_next    = dvs_reg;
      sgn_next    = sgn_reg;
      neg_q_next  = neg_q_reg;
      neg_r_next  = neg_r_reg;
      result_next = result_reg;
      ready_next  = ready_reg;

      case (state_reg)
         IDLE: begin
            ready_next = 1'b0;
            if (start) begin
               if (divisor == '0) begin
                  state_next = BY_ZERO;
               end else begin
                  state_next = ON;
                  cnt_next   = '0;
                  rem_next   = '0;
                  quo_next   = abs_dvd;
                  dvs_next   = abs_dvs;
                  sgn_next   = signed_div;
                  neg_r_next = dividend[DATA_W-1];
                  neg_q_next = dividend[DATA_W-1] ^ divisor[DATA_W-1];
               end
            end
         end
         BY_ZERO: begin
            state_next  = END;
            result_next = '0;
         end
         ON: begin
            rem_next = rem_step;
            quo_next = quo_step;
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == LAST_ITER) begin
               state_next  = END;
               result_next = {rem_fix, quo_fix};
            end
         end
         END: begin
            ready_next = 1'b1;
            if (!start) begin
               state_next = IDLE;
               ready_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase

      // Flush wins over everything, including a same-cycle start.
      if (annul) begin
         state_next  = IDLE;
         ready_next  = 1'b0;
         result_next = '0;
         cnt_next    = '0;
      end
   end

   assign result = result_reg;
   assign ready  = ready_reg;
   assign busy   = (state_reg != IDLE);

endmodule
